// File: rtl/rv_pkg.sv
// rv_pkg: definitions shared across the barrel RV32I core.
//   - Default thread-count parameters, shared with mt_pc.
//   - Branch-condition encodings (funct3) used by br_cmp.
// No ports (package).
package rv_pkg;

  localparam int NUM_THREADS_DEF  = 8;
  localparam int BITS_THREADS_DEF = $clog2(NUM_THREADS_DEF);

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/br_cmp.sv
// br_cmp: combinational branch-condition evaluator.
// Ports:
//   i_rs1, i_rs2  in  DATA_WIDTH  operands
//   i_funct3      in  3           branch condition (rv_pkg::br_funct3_e)
//   o_cond        out 1           condition holds; encodings 010/011 never hold
module br_cmp
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  input  logic [2:0]            i_funct3,
  output logic                  o_cond
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      BR_EQ:   o_cond = w_eq;
      BR_NE:   o_cond = ~w_eq;
      BR_LT:   o_cond = w_lt;
      BR_GE:   o_cond = ~w_lt;
      BR_LTU:  o_cond = w_ltu;
      BR_GEU:  o_cond = ~w_ltu;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/mt_branch_unit.sv
// mt_branch_unit: execute-stage branch/jump resolver for the barrel RV32I core.
// Drives the fetch redirect (pc_src_e/branch_tid_e/pc_target_e) into mt_pc one
// cycle after resolve and keeps a per-thread epoch bit that flips on every
// redirect, so in-flight instructions of that thread fetched before the
// redirect arrive with a stale tag and are squashed.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   valid_e, tid_e, epoch_e  execute-slot instruction, its thread and epoch tag
//   branch_e/jump_e/jalr_e   instruction class (priority jalr > jal > branch)
//   funct3_e, rs1_e, rs2_e   branch condition and forwarded operands
//   pc_e, imm_e              instruction PC and sign-extended immediate
//   pc_src_e, branch_tid_e, pc_target_e   registered redirect
//   squash_e                 execute-slot instruction carries a stale epoch
//   epoch_q                  current epoch bit per thread
// Optional feature (macro BRANCH_STATS_EN): per-thread saturating taken
// counters with a combinational read port stat_tid/stat_count.
module mt_branch_unit
  import rv_pkg::*;
#(
  parameter int NUM_THREADS   = NUM_THREADS_DEF,
  parameter int BITS_THREADS  = $clog2(NUM_THREADS),
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_e,
  input  logic [BITS_THREADS-1:0]  tid_e,
  input  logic                     epoch_e,
  input  logic                     branch_e,
  input  logic                     jump_e,
  input  logic                     jalr_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    rs1_e,
  input  logic [DATA_WIDTH-1:0]    rs2_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_e,
  input  logic [ADDRESS_WIDTH-1:0] imm_e,
`ifdef BRANCH_STATS_EN
  input  logic [BITS_THREADS-1:0]  stat_tid,
  output logic [STAT_WIDTH-1:0]    stat_count,
`endif
  output logic                     pc_src_e,
  output logic [BITS_THREADS-1:0]  branch_tid_e,
  output logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     squash_e,
  output logic [NUM_THREADS-1:0]   epoch_q
);

  logic                     r_pc_src;
  logic [BITS_THREADS-1:0]  r_branch_tid;
  logic [ADDRESS_WIDTH-1:0] r_pc_target;
  logic [NUM_THREADS-1:0]   r_epoch;

  logic                     w_live;
  logic                     w_cond;
  logic                     w_taken;
  logic [ADDRESS_WIDTH-1:0] w_jalr_sum;
  logic [ADDRESS_WIDTH-1:0] w_target;

  br_cmp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_br_cmp (
    .i_rs1    (rs1_e),
    .i_rs2    (rs2_e),
    .i_funct3 (funct3_e),
    .o_cond   (w_cond)
  );

  assign w_live   = valid_e & (epoch_e == r_epoch[tid_e]);
  assign squash_e = valid_e & ~w_live;
  assign w_taken  = w_live & (jump_e | jalr_e | (branch_e & w_cond));

  // JALR clears bit 0 of the sum; JAL and branches are PC-relative.
  // Additions wrap at ADDRESS_WIDTH bits.
  assign w_jalr_sum = ADDRESS_WIDTH'(rs1_e) + imm_e;
  assign w_target   = jalr_e ? (w_jalr_sum & ~ADDRESS_WIDTH'(1)) : (pc_e + imm_e);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_src     <= 1'b0;
      r_branch_tid <= '0;
      r_pc_target  <= '0;
      r_epoch      <= '0;
    end else begin
      r_pc_src <= w_taken;
      if (w_taken) begin
        r_branch_tid   <= tid_e;
        r_pc_target    <= w_target;
        r_epoch[tid_e] <= ~r_epoch[tid_e];
      end
    end
  end

  assign pc_src_e     = r_pc_src;
  assign branch_tid_e = r_branch_tid;
  assign pc_target_e  = r_pc_target;
  assign epoch_q      = r_epoch;

`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_cnt [NUM_THREADS];

  // Counter advances on the same edge that registers the redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) r_stat_cnt[i] <= '0;
    end else if (w_taken && (r_stat_cnt[tid_e] != {STAT_WIDTH{1'b1}})) begin
      r_stat_cnt[tid_e] <= r_stat_cnt[tid_e] + STAT_WIDTH'(1);
    end
  end

  assign stat_count = r_stat_cnt[stat_tid];
`endif

endmodule

// File: tb/tb_mt_branch_unit.sv
// Directed testbench for mt_branch_unit; expected values are hand-computed.
module tb_mt_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_e = 1'b0;
  logic [2:0]  tid_e = '0;
  logic        epoch_e = 1'b0;
  logic        branch_e = 1'b0;
  logic        jump_e = 1'b0;
  logic        jalr_e = 1'b0;
  logic [2:0]  funct3_e = '0;
  logic [31:0] rs1_e = '0;
  logic [31:0] rs2_e = '0;
  logic [31:0] pc_e = '0;
  logic [31:0] imm_e = '0;
  logic        pc_src_e;
  logic [2:0]  branch_tid_e;
  logic [31:0] pc_target_e;
  logic        squash_e;
  logic [7:0]  epoch_q;
`ifdef BRANCH_STATS_EN
  logic [2:0]  stat_tid = 3'd1;
  logic [15:0] stat_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mt_branch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .valid_e      (valid_e),
    .tid_e        (tid_e),
    .epoch_e      (epoch_e),
    .branch_e     (branch_e),
    .jump_e       (jump_e),
    .jalr_e       (jalr_e),
    .funct3_e     (funct3_e),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .pc_e         (pc_e),
    .imm_e        (imm_e),
`ifdef BRANCH_STATS_EN
    .stat_tid     (stat_tid),
    .stat_count   (stat_count),
`endif
    .pc_src_e     (pc_src_e),
    .branch_tid_e (branch_tid_e),
    .pc_target_e  (pc_target_e),
    .squash_e     (squash_e),
    .epoch_q      (epoch_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new execute-slot instruction just after the falling edge.
  task automatic issue(input logic v, input logic [2:0] t, input logic ep,
                       input logic br, input logic j, input logic jr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    @(negedge clk);
    valid_e = v; tid_e = t; epoch_e = ep; branch_e = br; jump_e = j; jalr_e = jr;
    funct3_e = f3; rs1_e = a; rs2_e = b; pc_e = pc; imm_e = imm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_pc_src", {31'd0, pc_src_e}, 32'd0);
    check("rst_tid", {29'd0, branch_tid_e}, 32'd0);
    check("rst_target", pc_target_e, 32'd0);
    check("rst_epoch", {24'd0, epoch_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: BEQ tid3 taken
    issue(1, 3'd3, 0, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    check("beq_squash", {31'd0, squash_e}, 32'd0);
    tick();
    check("beq_pc_src", {31'd0, pc_src_e}, 32'd1);
    check("beq_tid", {29'd0, branch_tid_e}, 32'd3);
    check("beq_target", pc_target_e, 32'h120);
    check("beq_epoch", {24'd0, epoch_q}, 32'h08);

    // Idle: strobe drops, tid/target hold
    issue(0, 3'd0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0);
    tick();
    check("idle_pc_src", {31'd0, pc_src_e}, 32'd0);
    check("idle_tid_hold", {29'd0, branch_tid_e}, 32'd3);
    check("idle_target_hold", pc_target_e, 32'h120);

    // 2: BNE equal, 010/011 never taken, BNE unequal taken
    issue(1, 3'd0, 0, 1, 0, 0, 3'b001, 32'd7, 32'd7, 32'h200, 32'h10);
    tick();
    check("bne_eq_not_taken", {31'd0, pc_src_e}, 32'd0);
    issue(1, 3'd0, 0, 1, 0, 0, 3'b010, 32'd1, 32'd2, 32'h200, 32'h10);
    tick();
    check("f3_010_not_taken", {31'd0, pc_src_e}, 32'd0);
    issue(1, 3'd0, 0, 1, 0, 0, 3'b011, 32'd1, 32'd1, 32'h200, 32'h10);
    tick();
    check("f3_011_not_taken", {31'd0, pc_src_e}, 32'd0);
    issue(1, 3'd0, 0, 1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h200, 32'h10);
    tick();
    check("bne_ne_taken", {31'd0, pc_src_e}, 32'd1);
    check("bne_target", pc_target_e, 32'h210);
    check("bne_epoch", {24'd0, epoch_q}, 32'h09);

    // 3: signed vs unsigned
    issue(1, 3'd1, 0, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h8);
    tick();
    check("blt_taken", {31'd0, pc_src_e}, 32'd1);
    check("blt_target", pc_target_e, 32'h308);
    check("blt_epoch", {24'd0, epoch_q}, 32'h0B);
    issue(1, 3'd4, 0, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h4);
    tick();
    check("bltu_not_taken", {31'd0, pc_src_e}, 32'd0);
    issue(1, 3'd4, 0, 1, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h4);
    tick();
    check("bge_not_taken", {31'd0, pc_src_e}, 32'd0);
    issue(1, 3'd4, 0, 1, 0, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h4);
    tick();
    check("bgeu_taken", {31'd0, pc_src_e}, 32'd1);
    check("bgeu_target", pc_target_e, 32'h404);
    check("bgeu_epoch", {24'd0, epoch_q}, 32'h1B);

    // 4: JALR bit0 clear, JAL wrap, jalr priority over jump
    issue(1, 3'd6, 0, 0, 0, 1, 3'b000, 32'h1001, 32'd0, 32'h500, 32'h2);
    tick();
    check("jalr_taken", {31'd0, pc_src_e}, 32'd1);
    check("jalr_target", pc_target_e, 32'h1002);
    check("jalr_tid", {29'd0, branch_tid_e}, 32'd6);
    issue(1, 3'd7, 0, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'hFFFF_FFF0, 32'h20);
    tick();
    check("jal_wrap_target", pc_target_e, 32'h10);
    check("jal_epoch", {24'd0, epoch_q}, 32'hDB);
    issue(1, 3'd6, 1, 1, 1, 1, 3'b010, 32'h2000, 32'd0, 32'h600, 32'h11);
    tick();
    check("prio_jalr_target", pc_target_e, 32'h2010);
    check("prio_epoch", {24'd0, epoch_q}, 32'h9B);

    // 5: stale epoch squash, other thread unaffected, back-to-back redirects
    issue(1, 3'd2, 0, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h600, 32'h40);
    tick();
    check("t2_target", pc_target_e, 32'h640);
    check("t2_epoch", {24'd0, epoch_q}, 32'h9F);
    issue(1, 3'd2, 0, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h610, 32'h40);
    check("stale_squash", {31'd0, squash_e}, 32'd1);
    tick();
    check("stale_no_redirect", {31'd0, pc_src_e}, 32'd0);
    check("stale_epoch_same", {24'd0, epoch_q}, 32'h9F);
    check("stale_target_hold", pc_target_e, 32'h640);
    issue(1, 3'd5, 0, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h700, 32'h4);
    check("t5_no_squash", {31'd0, squash_e}, 32'd0);
    tick();
    check("t5_pc_src", {31'd0, pc_src_e}, 32'd1);
    check("t5_target", pc_target_e, 32'h704);
    issue(1, 3'd3, 1, 1, 0, 0, 3'b000, 32'd9, 32'd9, 32'h800, 32'h8);
    tick();
    check("b2b_pc_src", {31'd0, pc_src_e}, 32'd1);
    check("b2b_tid", {29'd0, branch_tid_e}, 32'd3);
    check("b2b_target", pc_target_e, 32'h808);
    check("b2b_epoch", {24'd0, epoch_q}, 32'hB7);
    issue(0, 3'd0, 1, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h900, 32'h4);
    check("invalid_no_squash", {31'd0, squash_e}, 32'd0);
    tick();
    check("invalid_no_redirect", {31'd0, pc_src_e}, 32'd0);
    check("invalid_epoch_same", {24'd0, epoch_q}, 32'hB7);

    // 6: async reset while a redirect is on the outputs
    issue(1, 3'd0, 1, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h900, 32'h0);
    tick();
    check("pre_rst_pc_src", {31'd0, pc_src_e}, 32'd1);
    check("pre_rst_epoch", {24'd0, epoch_q}, 32'hB6);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_pc_src", {31'd0, pc_src_e}, 32'd0);
    check("mid_rst_tid", {29'd0, branch_tid_e}, 32'd0);
    check("mid_rst_target", pc_target_e, 32'd0);
    check("mid_rst_epoch", {24'd0, epoch_q}, 32'd0);
    issue(0, 3'd0, 0, 0, 0, 0, 3'b000, 32'h0, 32'd0, 32'h0, 32'h0);
    rst = 1'b0;

`ifdef BRANCH_STATS_EN
    begin
      logic e;
      e = 1'b0;
      for (int i = 0; i < 3; i++) begin
        issue(1, 3'd1, e, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h100, 32'h4);
        tick();
        e = ~e;
      end
      check("stat_three", {16'd0, stat_count}, 32'd3);
      for (int i = 0; i < 65532; i++) begin
        issue(1, 3'd1, e, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h100, 32'h4);
        tick();
        e = ~e;
      end
      check("stat_full", {16'd0, stat_count}, 32'hFFFF);
      issue(1, 3'd1, e, 0, 1, 0, 3'b000, 32'h0, 32'd0, 32'h100, 32'h4);
      tick();
      check("stat_saturate", {16'd0, stat_count}, 32'hFFFF);
      issue(0, 3'd0, 0, 0, 0, 0, 3'b000, 32'h0, 32'd0, 32'h0, 32'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
